// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase stepper.
package pll_phase_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARESET = 3'd1,
    SETUP  = 3'd2,
    STEP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // PLL phasecounterselect encodings
  localparam logic [2:0] SEL_ALL = 3'b000;
  localparam logic [2:0] SEL_M   = 3'b001;
  localparam logic [2:0] SEL_C0  = 3'b010;
  localparam logic [2:0] SEL_C1  = 3'b011;
  localparam logic [2:0] SEL_C2  = 3'b100;
  localparam logic [2:0] SEL_C3  = 3'b101;
  localparam logic [2:0] SEL_C4  = 3'b110;

endpackage

// File: rtl/pll_scanclk_div.sv
// scanclk divider: strobes toggle once every DIV enabled cycles and counts
// the scanclk half-cycles generated since the last clear.
module pll_scanclk_div #(
  parameter int DIV  = 16,
  parameter int HC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  output logic            toggle,
  output logic [HC_W-1:0] hc
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign toggle = enable && (cnt == CNT_LAST);

  // Divider count and half-cycle counter; hc advances on each toggle strobe
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      hc  <= '0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        hc  <= hc + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift port: optional areset pulse, then one
// SETUP/STEP pass per requested phase step, tracking the net phase position.
// Handshake: a command is taken on a cycle where cmd_valid and cmd_ready are
// both high; cmd_ready is high only in IDLE, so cmd_valid is ignored while busy.
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int SCANCLK_DIV   = 16,
  parameter int STEP_W        = 8,
  parameter int NPHASES       = 64,
  parameter int ARESET_CYCLES = 8,
  parameter int ASSERT_HC     = 6,
  parameter int MIN_HC        = 8,
  parameter int TIMEOUT_HC    = 108,
  localparam int POS_W        = (NPHASES > 1) ? $clog2(NPHASES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_sel,
  input  logic              cmd_updown,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_areset,
  input  logic              phase_done,
  output logic              areset,
  output logic [2:0]        phasecounterselect,
  output logic              phaseupdown,
  output logic              phasestep,
  output logic              scanclk,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [STEP_W-1:0] steps_done,
  output logic [POS_W-1:0]  phase_pos,
  output state_t            fsm_state
);

  localparam int HC_W = $clog2(TIMEOUT_HC + 1) + 1;
  localparam int AR_W = $clog2(ARESET_CYCLES) + 1;
  localparam logic [HC_W-1:0]  HC_ASSERT  = HC_W'(ASSERT_HC);
  localparam logic [HC_W-1:0]  HC_MIN     = HC_W'(MIN_HC);
  localparam logic [HC_W-1:0]  HC_TIMEOUT = HC_W'(TIMEOUT_HC);
  localparam logic [AR_W-1:0]  AR_LAST    = AR_W'(ARESET_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NPHASES - 1);

  state_t            state, state_next;
  logic [2:0]        sel_q;
  logic              updown_q;
  logic [STEP_W-1:0] steps_q;
  logic              abort_q;
  logic [AR_W-1:0]   ar_cnt;
  logic              pd_meta, pd_sync;
  logic              toggle;
  logic [HC_W-1:0]   hc, hc_next;
  logic              accept, step_complete, step_timeout, more_steps;
  logic              enter_setup, enter_done;
  logic [2:0]        setup_sel;
  logic              setup_updown;

  assign accept        = cmd_valid && (state == IDLE);
  assign hc_next       = hc + 1'b1;
  assign step_complete = (state == STEP) && toggle && (hc_next >= HC_MIN) && pd_sync;
  assign step_timeout  = (state == STEP) && toggle && !step_complete && (hc_next >= HC_TIMEOUT);
  assign more_steps    = ({1'b0, steps_done} + 1'b1) < {1'b0, steps_q};
  assign enter_setup   = (state_next == SETUP) && (state != SETUP);
  assign enter_done    = (state_next == DONE) && (state != DONE);
  // Entering SETUP straight from IDLE happens before the command fields land
  assign setup_sel     = (state == IDLE) ? cmd_sel : sel_q;
  assign setup_updown  = (state == IDLE) ? cmd_updown : updown_q;
  assign fsm_state     = state;

  pll_scanclk_div #(
    .DIV  (SCANCLK_DIV),
    .HC_W (HC_W)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (state == STEP),
    .clear  (state == SETUP),
    .toggle (toggle),
    .hc     (hc)
  );

  // Two-flop synchroniser for the asynchronous phasedone
  always_ff @(posedge clk) begin
    if (reset) begin
      pd_meta <= 1'b0;
      pd_sync <= 1'b0;
    end else begin
      pd_meta <= phase_done;
      pd_sync <= pd_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_areset)             state_next = ARESET;
          else if (cmd_steps == '0)   state_next = DONE;
          else                        state_next = SETUP;
        end
      end
      ARESET: begin
        if (ar_cnt == AR_LAST) state_next = (steps_q == '0) ? DONE : SETUP;
      end
      SETUP: state_next = STEP;
      STEP: begin
        if (step_complete)     state_next = more_steps ? SETUP : DONE;
        else if (step_timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready   = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == DONE);
    timeout_err = (state == DONE) && abort_q;
    areset      = (state == ARESET);
  end

  // areset hold counter, runs only while in ARESET
  always_ff @(posedge clk) begin
    if (reset || (state != ARESET)) ar_cnt <= '0;
    else                            ar_cnt <= ar_cnt + 1'b1;
  end

  // Command latch, PLL control pins, step and phase bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q              <= SEL_ALL;
      updown_q           <= 1'b1;
      steps_q            <= '0;
      abort_q            <= 1'b0;
      steps_done         <= '0;
      phase_pos          <= '0;
      phasecounterselect <= SEL_ALL;
      phaseupdown        <= 1'b1;
      phasestep          <= 1'b0;
      scanclk            <= 1'b0;
    end else begin
      if (accept) begin
        sel_q      <= cmd_sel;
        updown_q   <= cmd_updown;
        steps_q    <= cmd_steps;
        abort_q    <= 1'b0;
        steps_done <= '0;
      end
      if (state == ARESET) phase_pos <= '0;

      // Forced levels on SETUP/DONE entry take priority over a toggle
      if (enter_setup) begin
        phasecounterselect <= setup_sel;
        phaseupdown        <= setup_updown;
        phasestep          <= 1'b1;
        scanclk            <= 1'b0;
      end else if (enter_done) begin
        phasestep <= 1'b0;
        scanclk   <= 1'b0;
      end else if ((state == STEP) && toggle) begin
        scanclk <= ~scanclk;
        if (hc_next == HC_ASSERT) phasestep <= 1'b0;
      end

      if (step_complete) begin
        steps_done <= steps_done + 1'b1;
        if (updown_q) phase_pos <= (phase_pos == POS_LAST) ? '0 : phase_pos + 1'b1;
        else          phase_pos <= (phase_pos == '0) ? POS_LAST : phase_pos - 1'b1;
      end
      if (step_timeout) abort_q <= 1'b1;
    end
  end

endmodule
